can_error_manager: RTL and testbench

- Central CAN error-handling controller.
- Collects the per-bit error monitors (bit, stuff, CRC, form, ACK) and maintains the transmit and receive error counters.
- Derives the fault-confinement state and sequences error-frame transmission (flag plus delimiter) onto the TX bit path.
- Sits between the error monitors and the bit-stream transmitter; the transmitter muxes o_Tx_Bit in while o_Err_Frame is high.

---
 rtl/can_pkg.sv | 27 ++
 rtl/can_fault_counters.sv | 97 +++++++++
 rtl/can_error_manager.sv | 145 ++++++++++++++
 tb/tb_can_error_manager.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN error-handling types: error-FSM states, fault-confinement encodings,
// counter limits and the frame-field codes also used by the bit-error monitors.
package can_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLAG,
    ST_WAIT_REC,
    ST_DELIM,
    ST_BUSOFF
  } err_fsm_e;

  typedef enum logic [1:0] {
    ERR_ACTIVE  = 2'b00,
    ERR_PASSIVE = 2'b01,
    ERR_BUSOFF  = 2'b10
  } err_state_e;

  localparam int WARN_LIM    = 96;
  localparam int PASSIVE_LIM = 128;
  localparam int BUSOFF_LIM  = 256;

  localparam logic [4:0] FIELD_CRC_DELIM = 5'b10001;
  localparam logic [4:0] FIELD_ACK_DELIM = 5'b10010;
  localparam logic [4:0] FIELD_EOF       = 5'b00101;

endpackage

// File: rtl/can_fault_counters.sv
// TEC/REC arithmetic with saturation and the registered fault-confinement state.
// Optional o_Err_Warning path is built only when CAN_ERR_WARNING_EN is defined.
module can_fault_counters import can_pkg::*; #(
  parameter int PASSIVE_LIMIT = PASSIVE_LIM,
  parameter int BUSOFF_LIMIT  = BUSOFF_LIM
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       err_evt,
  input  logic       frame_ok,
  input  logic       transmitter,
  input  logic       recover,
  output logic [8:0] tec,
  output logic [7:0] rec,
`ifdef CAN_ERR_WARNING_EN
  output logic       err_warning,
`endif
  output logic [1:0] err_state,
  output logic       busoff_next
);

  logic [8:0] tec_q, tec_d;
  logic [7:0] rec_q, rec_d;
  err_state_e state_q;

  function automatic logic [8:0] tec_add_sat(input logic [8:0] t);
    logic [9:0] s;
    s = {1'b0, t} + 10'd8;
    return (s > 10'd256) ? 9'd256 : s[8:0];
  endfunction

  function automatic logic [7:0] rec_inc_sat(input logic [7:0] r);
    return (r == 8'hFF) ? 8'hFF : r + 8'd1;
  endfunction

  function automatic logic [7:0] rec_frame_ok(input logic [7:0] r);
    if (r > 8'd127)
      return 8'd127;
    return (r != 8'd0) ? r - 8'd1 : 8'd0;
  endfunction

  function automatic err_state_e derive_state(input logic [8:0] t, input logic [7:0] r);
    if (t >= 9'(BUSOFF_LIMIT))
      return ERR_BUSOFF;
    if ((t >= 9'(PASSIVE_LIMIT)) || ({1'b0, r} >= 9'(PASSIVE_LIMIT)))
      return ERR_PASSIVE;
    return ERR_ACTIVE;
  endfunction

  // An error on the same strobe as a frame-ok takes priority.
  always_comb begin
    tec_d = tec_q;
    rec_d = rec_q;
    if (recover) begin
      tec_d = 9'd0;
      rec_d = 8'd0;
    end else if (err_evt) begin
      if (transmitter) tec_d = tec_add_sat(tec_q);
      else             rec_d = rec_inc_sat(rec_q);
    end else if (frame_ok) begin
      if (transmitter) tec_d = (tec_q != 9'd0) ? tec_q - 9'd1 : 9'd0;
      else             rec_d = rec_frame_ok(rec_q);
    end
  end

  assign busoff_next = (tec_d >= 9'(BUSOFF_LIMIT));

  // State is derived from the registered counters, so it trails them by a clock.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tec_q   <= 9'd0;
      rec_q   <= 8'd0;
      state_q <= ERR_ACTIVE;
    end else begin
      tec_q   <= tec_d;
      rec_q   <= rec_d;
      state_q <= recover ? ERR_ACTIVE : derive_state(tec_q, rec_q);
    end
  end

`ifdef CAN_ERR_WARNING_EN
  logic warn_q;
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset)
      warn_q <= 1'b0;
    else
      warn_q <= !recover && (tec_q < 9'(BUSOFF_LIMIT)) &&
                ((tec_q >= 9'(WARN_LIM)) || ({1'b0, rec_q} >= 9'(WARN_LIM)));
  end
  assign err_warning = warn_q;
`endif

  assign tec       = tec_q;
  assign rec       = rec_q;
  assign err_state = state_q;

endmodule

// File: rtl/can_error_manager.sv
// CAN error controller: error-frame sequencing (flag + delimiter) and bus-off recovery.
// Define CAN_ERR_WARNING_EN to add the o_Err_Warning output.
module can_error_manager import can_pkg::*; #(
  parameter int FLAG_BITS     = 6,
  parameter int DELIM_BITS    = 8,
  parameter int PASSIVE_LIMIT = PASSIVE_LIM,
  parameter int BUSOFF_LIMIT  = BUSOFF_LIM,
  parameter int RECOVERY_SEQS = 128
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Sample,
  input  logic       i_Data,
  input  logic       i_Transmitter,
  input  logic       i_Bit_Err,
  input  logic       i_Stuff_Err,
  input  logic       i_Crc_Err,
  input  logic       i_Form_Err,
  input  logic       i_Ack_Err,
  input  logic       i_Frame_Ok,
  output logic       o_Err_Frame,
  output logic       o_Tx_Bit,
  output logic [8:0] o_Tec,
  output logic [7:0] o_Rec,
`ifdef CAN_ERR_WARNING_EN
  output logic       o_Err_Warning,
`endif
  output logic [1:0] o_Err_State
);

  localparam int SEQ_W = $clog2(RECOVERY_SEQS + 1);

  err_fsm_e         state_q, state_d;
  logic [7:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       run_q, run_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             any_err, err_evt, frame_ok, recover, busoff_next;
  logic [1:0]       err_state;

  assign any_err  = i_Bit_Err | i_Stuff_Err | i_Crc_Err | i_Form_Err | i_Ack_Err;
  assign err_evt  = i_Sample && (state_q == ST_IDLE) && any_err;
  assign frame_ok = i_Sample && (state_q == ST_IDLE) && i_Frame_Ok && !any_err;

  can_fault_counters #(
    .PASSIVE_LIMIT (PASSIVE_LIMIT),
    .BUSOFF_LIMIT  (BUSOFF_LIMIT)
  ) u_counters (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .err_evt     (err_evt),
    .frame_ok    (frame_ok),
    .transmitter (i_Transmitter),
    .recover     (recover),
    .tec         (o_Tec),
    .rec         (o_Rec),
`ifdef CAN_ERR_WARNING_EN
    .err_warning (o_Err_Warning),
`endif
    .err_state   (err_state),
    .busoff_next (busoff_next)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 8'd0;
      run_q     <= 4'd0;
      seq_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      run_q     <= run_d;
      seq_q     <= seq_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    run_d     = run_q;
    seq_d     = seq_q;
    recover   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (err_evt) begin
          bit_cnt_d = 8'd0;
          run_d     = 4'd0;
          seq_d     = '0;
          state_d   = busoff_next ? ST_BUSOFF : ST_FLAG;
        end
      end
      ST_FLAG: begin
        if (i_Sample) begin
          if (bit_cnt_q == 8'(FLAG_BITS - 1)) begin
            bit_cnt_d = 8'd0;
            state_d   = ST_WAIT_REC;
          end else begin
            bit_cnt_d = bit_cnt_q + 8'd1;
          end
        end
      end
      // First recessive strobe after the flag is delimiter bit 1.
      ST_WAIT_REC: begin
        if (i_Sample && i_Data) begin
          bit_cnt_d = 8'd1;
          state_d   = (DELIM_BITS <= 1) ? ST_IDLE : ST_DELIM;
        end
      end
      ST_DELIM: begin
        if (i_Sample) begin
          if (bit_cnt_q == 8'(DELIM_BITS - 1)) begin
            bit_cnt_d = 8'd0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 8'd1;
          end
        end
      end
      ST_BUSOFF: begin
        if (i_Sample) begin
          if (!i_Data) begin
            run_d = 4'd0;
          end else if (run_q == 4'd10) begin
            run_d = 4'd0;
            if (seq_q == SEQ_W'(RECOVERY_SEQS - 1)) begin
              seq_d   = '0;
              recover = 1'b1;
              state_d = ST_IDLE;
            end else begin
              seq_d = seq_q + 1'b1;
            end
          end else begin
            run_d = run_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_Err_Frame = (state_q == ST_FLAG) || (state_q == ST_WAIT_REC) || (state_q == ST_DELIM);
  assign o_Tx_Bit    = !((state_q == ST_FLAG) && (err_state == ERR_ACTIVE));
  assign o_Err_State = err_state;

endmodule

// File: tb/tb_can_error_manager.sv
// Self-checking bench for can_error_manager: directed scenarios plus randomized
// strobes compared against a bit-time level reference model.
module tb_can_error_manager;

  localparam int FLAG_N  = 6;
  localparam int DELIM_N = 8;
  localparam int SEQ_N   = 128;
  localparam logic [4:0] E_BIT = 5'b10000, E_STUFF = 5'b01000, E_CRC = 5'b00100,
                         E_FORM = 5'b00010, E_ACK = 5'b00001, E_NONE = 5'b00000;

  logic i_Clock = 1'b0, i_Reset = 1'b1, i_Sample = 1'b0, i_Data = 1'b1, i_Transmitter = 1'b0;
  logic i_Bit_Err = 1'b0, i_Stuff_Err = 1'b0, i_Crc_Err = 1'b0, i_Form_Err = 1'b0, i_Ack_Err = 1'b0;
  logic i_Frame_Ok = 1'b0;
  logic o_Err_Frame, o_Tx_Bit;
  logic [8:0] o_Tec;
  logic [7:0] o_Rec;
  logic [1:0] o_Err_State;
`ifdef CAN_ERR_WARNING_EN
  logic o_Err_Warning;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_tec, m_rec, m_flag_left, m_delim_left, m_run, m_seq;
  bit m_wait, m_busoff;

  can_error_manager dut (
    .i_Clock       (i_Clock),
    .i_Reset       (i_Reset),
    .i_Sample      (i_Sample),
    .i_Data        (i_Data),
    .i_Transmitter (i_Transmitter),
    .i_Bit_Err     (i_Bit_Err),
    .i_Stuff_Err   (i_Stuff_Err),
    .i_Crc_Err     (i_Crc_Err),
    .i_Form_Err    (i_Form_Err),
    .i_Ack_Err     (i_Ack_Err),
    .i_Frame_Ok    (i_Frame_Ok),
    .o_Err_Frame   (o_Err_Frame),
    .o_Tx_Bit      (o_Tx_Bit),
    .o_Tec         (o_Tec),
    .o_Rec         (o_Rec),
`ifdef CAN_ERR_WARNING_EN
    .o_Err_Warning (o_Err_Warning),
`endif
    .o_Err_State   (o_Err_State)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic model_clear();
    m_tec = 0; m_rec = 0; m_flag_left = 0; m_delim_left = 0;
    m_run = 0; m_seq = 0; m_wait = 0; m_busoff = 0;
  endtask

  task automatic model_strobe(input bit d, input bit err, input bit fok, input bit tx);
    if (m_busoff) begin
      if (d) begin
        m_run++;
        if (m_run == 11) begin
          m_run = 0;
          m_seq++;
          if (m_seq == SEQ_N) begin
            m_tec = 0; m_rec = 0; m_seq = 0; m_busoff = 0;
          end
        end
      end else begin
        m_run = 0;
      end
    end else if (m_flag_left > 0) begin
      m_flag_left--;
      if (m_flag_left == 0) m_wait = 1;
    end else if (m_wait) begin
      if (d) begin
        m_wait = 0;
        m_delim_left = DELIM_N - 1;
      end
    end else if (m_delim_left > 0) begin
      m_delim_left--;
    end else if (err) begin
      if (tx) m_tec = (m_tec + 8 > 256) ? 256 : m_tec + 8;
      else    m_rec = (m_rec + 1 > 255) ? 255 : m_rec + 1;
      if (m_tec >= 256) begin
        m_busoff = 1; m_run = 0; m_seq = 0;
      end else begin
        m_flag_left = FLAG_N;
      end
    end else if (fok) begin
      if (tx) m_tec = (m_tec > 0) ? m_tec - 1 : 0;
      else    m_rec = (m_rec > 127) ? 127 : ((m_rec > 0) ? m_rec - 1 : 0);
    end
  endtask

  task automatic do_reset();
    @(negedge i_Clock);
    i_Reset = 1'b1; i_Sample = 1'b0; i_Data = 1'b1; i_Frame_Ok = 1'b0;
    {i_Bit_Err, i_Stuff_Err, i_Crc_Err, i_Form_Err, i_Ack_Err} = E_NONE;
    @(negedge i_Clock);
    i_Reset = 1'b0;
    model_clear();
    @(negedge i_Clock);
  endtask

  // One bit time: a single-cycle sample strobe followed by settling clocks.
  task automatic strobe(input bit d, input logic [4:0] errs, input bit fok, input bit tx);
    @(negedge i_Clock);
    i_Data = d; i_Transmitter = tx; i_Frame_Ok = fok; i_Sample = 1'b1;
    {i_Bit_Err, i_Stuff_Err, i_Crc_Err, i_Form_Err, i_Ack_Err} = errs;
    @(negedge i_Clock);
    i_Sample = 1'b0; i_Frame_Ok = 1'b0;
    {i_Bit_Err, i_Stuff_Err, i_Crc_Err, i_Form_Err, i_Ack_Err} = E_NONE;
    @(negedge i_Clock);
    @(negedge i_Clock);
    model_strobe(d, |errs, fok, tx);
  endtask

  task automatic finish_frame(input bit tx);
    repeat (FLAG_N + DELIM_N) strobe(1'b1, E_NONE, 1'b0, tx);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (o_Err_Frame !== 1'b0) begin n_fail++; $display("FAIL reset_err_frame actual=%b required=0", o_Err_Frame); end
    n_checks++; if (o_Tx_Bit !== 1'b1) begin n_fail++; $display("FAIL reset_tx_bit actual=%b required=1", o_Tx_Bit); end
    n_checks++; if (o_Tec !== 9'd0) begin n_fail++; $display("FAIL reset_tec actual=%0d required=0", o_Tec); end
    n_checks++; if (o_Rec !== 8'd0) begin n_fail++; $display("FAIL reset_rec actual=%0d required=0", o_Rec); end
    n_checks++; if (o_Err_State !== 2'b00) begin n_fail++; $display("FAIL reset_state actual=%b required=00", o_Err_State); end
  endtask

  task automatic test_rx_form_err();
    int hi, lo;
    do_reset();
    strobe(1'b1, E_FORM, 1'b0, 1'b0);
    n_checks++; if (o_Rec !== 8'd1) begin n_fail++; $display("FAIL rx_form_rec actual=%0d required=1", o_Rec); end
    n_checks++; if (o_Err_State !== 2'b00) begin n_fail++; $display("FAIL rx_form_state actual=%b required=00", o_Err_State); end
    hi = 0; lo = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_Err_Frame === 1'b1) hi++;
      if (o_Err_Frame === 1'b1 && o_Tx_Bit === 1'b0) begin
        lo++;
        if (i >= FLAG_N) begin n_fail++; $display("FAIL rx_form_dominant_late strobe=%0d tx_bit=%b required=1", i, o_Tx_Bit); end
      end
      strobe(1'b1, E_NONE, 1'b0, 1'b0);
    end
    n_checks++; if (hi != FLAG_N + DELIM_N) begin n_fail++; $display("FAIL rx_form_frame_len actual=%0d required=%0d", hi, FLAG_N + DELIM_N); end
    n_checks++; if (lo != FLAG_N) begin n_fail++; $display("FAIL rx_form_flag_len actual=%0d required=%0d", lo, FLAG_N); end
    n_checks++; if (o_Err_Frame !== 1'b0) begin n_fail++; $display("FAIL rx_form_end actual=%b required=0", o_Err_Frame); end
  endtask

  task automatic test_tx_passive();
    do_reset();
    repeat (16) begin
      strobe(1'b1, E_BIT, 1'b0, 1'b1);
      finish_frame(1'b1);
    end
    n_checks++; if (o_Tec !== 9'd128) begin n_fail++; $display("FAIL tx16_tec actual=%0d required=128", o_Tec); end
    n_checks++; if (o_Err_State !== 2'b01) begin n_fail++; $display("FAIL tx16_state actual=%b required=01", o_Err_State); end
    strobe(1'b1, E_BIT, 1'b0, 1'b1);
    n_checks++; if (o_Err_Frame !== 1'b1) begin n_fail++; $display("FAIL tx17_frame actual=%b required=1", o_Err_Frame); end
    n_checks++; if (o_Tx_Bit !== 1'b1) begin n_fail++; $display("FAIL tx17_passive_flag actual=%b required=1", o_Tx_Bit); end
    n_checks++; if (o_Tec !== 9'd136) begin n_fail++; $display("FAIL tx17_tec actual=%0d required=136", o_Tec); end
    finish_frame(1'b1);
  endtask

  task automatic enter_busoff(input string tag);
    repeat (31) begin
      strobe(1'b1, E_BIT, 1'b0, 1'b1);
      finish_frame(1'b1);
    end
    strobe(1'b1, E_BIT, 1'b0, 1'b1);
    n_checks++; if (o_Tec !== 9'd256) begin n_fail++; $display("FAIL %s_busoff_tec actual=%0d required=256", tag, o_Tec); end
    n_checks++; if (o_Err_State !== 2'b10) begin n_fail++; $display("FAIL %s_busoff_state actual=%b required=10", tag, o_Err_State); end
    n_checks++; if (o_Err_Frame !== 1'b0 || o_Tx_Bit !== 1'b1) begin n_fail++; $display("FAIL %s_busoff_outputs frame=%b tx=%b required frame=0 tx=1", tag, o_Err_Frame, o_Tx_Bit); end
  endtask

  task automatic test_busoff_recovery();
    do_reset();
    enter_busoff("full");
    repeat (SEQ_N * 11 - 1) strobe(1'b1, E_NONE, 1'b0, 1'b0);
    n_checks++; if (o_Err_State !== 2'b10) begin n_fail++; $display("FAIL full_early_exit state=%b required=10", o_Err_State); end
    strobe(1'b1, E_NONE, 1'b0, 1'b0);
    n_checks++; if (o_Tec !== 9'd0 || o_Rec !== 8'd0) begin n_fail++; $display("FAIL full_recover_counters tec=%0d rec=%0d required 0/0", o_Tec, o_Rec); end
    n_checks++; if (o_Err_State !== 2'b00) begin n_fail++; $display("FAIL full_recover_state actual=%b required=00", o_Err_State); end
  endtask

  task automatic test_busoff_run_clear();
    do_reset();
    enter_busoff("runclr");
    repeat (5 * 11 + 10) strobe(1'b1, E_NONE, 1'b0, 1'b0);
    strobe(1'b0, E_NONE, 1'b0, 1'b0);
    repeat ((SEQ_N - 5) * 11 - 1) strobe(1'b1, E_NONE, 1'b0, 1'b0);
    n_checks++; if (o_Err_State !== 2'b10 || o_Tec !== 9'd256) begin n_fail++; $display("FAIL runclr_early_exit state=%b tec=%0d required 10/256", o_Err_State, o_Tec); end
    strobe(1'b1, E_NONE, 1'b0, 1'b0);
    n_checks++; if (o_Err_State !== 2'b00 || o_Tec !== 9'd0) begin n_fail++; $display("FAIL runclr_recover state=%b tec=%0d required 00/0", o_Err_State, o_Tec); end
  endtask

  task automatic test_same_strobe();
    do_reset();
    repeat (3) begin
      strobe(1'b1, E_STUFF, 1'b0, 1'b0);
      finish_frame(1'b0);
    end
    strobe(1'b1, E_CRC, 1'b1, 1'b0);
    n_checks++; if (o_Rec !== 8'd4) begin n_fail++; $display("FAIL crc_fok_rec actual=%0d required=4", o_Rec); end
    strobe(1'b0, E_BIT, 1'b0, 1'b1);
    strobe(1'b0, E_ACK, 1'b1, 1'b0);
    n_checks++; if (o_Tec !== 9'd0 || o_Rec !== 8'd4) begin n_fail++; $display("FAIL err_in_flag tec=%0d rec=%0d required 0/4", o_Tec, o_Rec); end
    finish_frame(1'b0);
    strobe(1'b1, E_NONE, 1'b1, 1'b0);
    n_checks++; if (o_Rec !== 8'd3) begin n_fail++; $display("FAIL rx_frame_ok_dec actual=%0d required=3", o_Rec); end
  endtask

  task automatic test_reset_in_delim();
    do_reset();
    strobe(1'b1, E_BIT, 1'b0, 1'b1);
    repeat (FLAG_N + 2) strobe(1'b1, E_NONE, 1'b0, 1'b1);
    n_checks++; if (o_Err_Frame !== 1'b1 || o_Tec !== 9'd8) begin n_fail++; $display("FAIL delim_precondition frame=%b tec=%0d required 1/8", o_Err_Frame, o_Tec); end
    @(negedge i_Clock);
    #1 i_Reset = 1'b1;
    #1;
    n_checks++; if (o_Err_Frame !== 1'b0 || o_Tx_Bit !== 1'b1) begin n_fail++; $display("FAIL async_reset_outputs frame=%b tx=%b required 0/1", o_Err_Frame, o_Tx_Bit); end
    n_checks++; if (o_Tec !== 9'd0 || o_Rec !== 8'd0) begin n_fail++; $display("FAIL async_reset_counters tec=%0d rec=%0d required 0/0", o_Tec, o_Rec); end
    @(negedge i_Clock);
    i_Reset = 1'b0;
    model_clear();
  endtask

  task automatic test_random();
    bit d, fok, tx, passive, exp_tx, exp_frame;
    logic [4:0] errs;
    int exp_state;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      d    = ($urandom_range(0, 9) < 7);
      errs = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : E_NONE;
      fok  = ($urandom_range(0, 5) == 0);
      tx   = ($urandom_range(0, 2) == 0);
      strobe(d, errs, fok, tx);
      passive   = (m_tec >= 128) || (m_rec >= 128);
      exp_frame = (m_flag_left > 0) || m_wait || (m_delim_left > 0);
      exp_tx    = (m_flag_left > 0) ? passive : 1'b1;
      exp_state = (m_tec >= 256) ? 2 : (passive ? 1 : 0);
      n_checks++; if (o_Tec !== 9'(m_tec)) begin n_fail++; $display("FAIL rnd_tec step=%0d actual=%0d required=%0d", i, o_Tec, m_tec); end
      n_checks++; if (o_Rec !== 8'(m_rec)) begin n_fail++; $display("FAIL rnd_rec step=%0d actual=%0d required=%0d", i, o_Rec, m_rec); end
      n_checks++; if (o_Err_State !== 2'(exp_state)) begin n_fail++; $display("FAIL rnd_state step=%0d actual=%b required=%0d", i, o_Err_State, exp_state); end
      n_checks++; if (o_Err_Frame !== exp_frame) begin n_fail++; $display("FAIL rnd_frame step=%0d actual=%b required=%b", i, o_Err_Frame, exp_frame); end
      n_checks++; if (o_Tx_Bit !== exp_tx) begin n_fail++; $display("FAIL rnd_tx_bit step=%0d actual=%b required=%b", i, o_Tx_Bit, exp_tx); end
`ifdef CAN_ERR_WARNING_EN
      n_checks++;
      if (o_Err_Warning !== ((m_tec >= 96 || m_rec >= 96) && m_tec < 256)) begin
        n_fail++; $display("FAIL rnd_warning step=%0d actual=%b", i, o_Err_Warning);
      end
`endif
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_rx_form_err();
    test_tx_passive();
    test_same_strobe();
    test_reset_in_delim();
    test_busoff_recovery();
    test_busoff_run_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
